engine_host_bridge: RTL and testbench
=====================================

# engine_host_bridge

Arbitrates the Logic Engine Interface (`lei`) Z3 channel and the Python Execution Engine (`pee`) Python channel onto one shared host mailbox. It sits directly downstream of `lei` and `pee`, in place of their combinational engine mocks, and owns the sequencing, round-robin fairness, per-transaction timeout and error synthesis for both engine channels.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 1024: WAIT cycles allowed without a host response before the bridge synthesizes an error (range 2..65535).

Ports:
- `clk` in 1: single clock; all state is on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `z3_req` in 1: LEI request level, held until `z3_ack`.
- `z3_formula_addr` in 32: formula address, stable while `z3_req` is high.
- `z3_ack` out 1: one-cycle completion pulse.
- `z3_result` out 32, `z3_sat` out 1, `z3_cert_hash` out 32: registered; valid in the `z3_ack` cycle and held until the next Z3 completion.
- `python_req` in 1, `python_code_addr` in 32: PEE request level and address, same rules as the Z3 channel.
- `python_ack` out 1: one-cycle completion pulse.
- `python_result` out 32, `python_error` out 1: registered, same hold rule as the Z3 outputs.
- `host_req_valid` out 1, `host_req_ready` in 1: valid/ready request handshake.
- `host_req_kind` out 1: 0 = Z3, 1 = Python.
- `host_req_addr` out 32: address of the granted request.
- `host_resp_valid` in 1: single-cycle response strobe; no backpressure.
- `host_resp_data` in 32, `host_resp_aux` in 32, `host_resp_flag` in 1: response payload.
- `bridge_busy` out 1: high in any state other than IDLE.
- `timeout_count` out 16, `spurious_count` out 16: saturating event counters.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: samples both request levels.
  - Exactly one request high: grant it.
  - Both high: grant the channel that was not granted last (`last_grant`). Reset value of `last_grant` is Python, so Z3 wins the first tie.
  - On grant: latch kind and address, drive `host_req_valid`=1, go to ISSUE.
- ISSUE: holds `host_req_valid`, `host_req_kind` and `host_req_addr` stable. Transfer occurs when valid && ready; the bridge then deasserts valid, clears the wait counter and goes to WAIT.
- WAIT: increments the 16-bit wait counter every cycle.
  - `host_resp_valid`=1: capture the response into the granted channel, go to DONE.
    - Z3: `z3_result`=`host_resp_data`, `z3_cert_hash`=`host_resp_aux`, `z3_sat`=`host_resp_flag`.
    - Python: `python_result`=`host_resp_data`, `python_error`=`host_resp_flag`.
  - Counter reaches `TIMEOUT_CYCLES`-1 with no response: synthesize the response, increment `timeout_count` (saturating at 0xFFFF), go to DONE.
    - Z3: result 0xFFFFFFFF, sat 0, cert 0.
    - Python: result 0, error 1.
  - Response and timeout in the same cycle: the response wins and no timeout is counted.
- DONE: pulse the granted channel's ack for one cycle, update `last_grant`, return to IDLE. Requests are not sampled in DONE, which gives the requester one cycle to drop its request.
- `host_resp_valid` seen in IDLE, ISSUE or DONE: ignored, and `spurious_count` increments (saturating).
- Outputs of the non-granted channel never change.

## Timing
- Reset values: all outputs 0, state IDLE, `last_grant`=Python, both counters 0.
- Asserting `rst_n` low mid-transaction aborts it immediately. No ack is issued, and the host must discard any response in flight.
- Cycle numbering from request sampled at edge k:
  - `host_req_valid`=1 after edge k (ISSUE).
  - Ready sampled high at edge k+1: WAIT from k+1.
  - Earliest response sampled at edge k+2: ack high from k+3 to k+4.
- Minimum latency from request to ack is 3 cycles.
- Back-to-back transactions: the next grant is at the IDLE edge after DONE, so the minimum period is 4 cycles.
- Timeout: with ready at edge k+1 and no response, ack is high from k+1+`TIMEOUT_CYCLES`+1.
- `host_req_valid` never drops without a transfer. Reset is the only exception.

## Test plan
- Z3 single transaction:
  - Stimulus: `z3_formula_addr`=0x00001234; host responds data 0xDEADACDB, aux 0xC0FFD234, flag 1.
  - Required: `host_req_kind`=0, `host_req_addr`=0x1234; one-cycle `z3_ack` with exactly those values; `python_ack` stays 0.
- Python single transaction:
  - Stimulus: `python_code_addr`=0x0000ABCD; host responds data 0x1234FDB5, flag 0.
  - Required: `python_ack` pulse, `python_result`=0x1234FDB5, `python_error`=0.
- Simultaneous requests, both held through two transactions:
  - Required: first grant Z3, second grant Python, each acked once. Host holds ready low for 5 cycles; `host_req_valid` and addr stay stable throughout.
- Timeout with `TIMEOUT_CYCLES`=8:
  - Stimulus: Z3 request, host never responds.
  - Required: `z3_ack` with result 0xFFFFFFFF, sat 0; `timeout_count`=1. A response arriving in the timeout cycle itself gives normal completion with the count unchanged.
- Spurious response:
  - Stimulus: `host_resp_valid` pulsed twice while IDLE.
  - Required: `spurious_count`=2, no ack, FSM stays IDLE.
- Reset mid-operation:
  - Stimulus: `rst_n` low during WAIT.
  - Required: all outputs 0 asynchronously; after release a Python request is acked normally; a late stale host response increments `spurious_count`.

Source files
------------

// File: rtl/engine_host_bridge_if.sv
// Signal bundle between the engine channels (LEI Z3, PEE Python), the host mailbox and the bridge.
// The master modport is the bridge; the slave modport is everything around it.
interface engine_host_bridge_if;
  logic        z3_req;
  logic [31:0] z3_formula_addr;
  logic        z3_ack;
  logic [31:0] z3_result;
  logic        z3_sat;
  logic [31:0] z3_cert_hash;

  logic        python_req;
  logic [31:0] python_code_addr;
  logic        python_ack;
  logic [31:0] python_result;
  logic        python_error;

  logic        host_req_valid;
  logic        host_req_ready;
  logic        host_req_kind;
  logic [31:0] host_req_addr;
  logic        host_resp_valid;
  logic [31:0] host_resp_data;
  logic [31:0] host_resp_aux;
  logic        host_resp_flag;

  logic        bridge_busy;
  logic [15:0] timeout_count;
  logic [15:0] spurious_count;

  modport master (
    input  z3_req, z3_formula_addr, python_req, python_code_addr,
    input  host_req_ready, host_resp_valid, host_resp_data, host_resp_aux, host_resp_flag,
    output z3_ack, z3_result, z3_sat, z3_cert_hash,
    output python_ack, python_result, python_error,
    output host_req_valid, host_req_kind, host_req_addr,
    output bridge_busy, timeout_count, spurious_count
  );

  modport slave (
    output z3_req, z3_formula_addr, python_req, python_code_addr,
    output host_req_ready, host_resp_valid, host_resp_data, host_resp_aux, host_resp_flag,
    input  z3_ack, z3_result, z3_sat, z3_cert_hash,
    input  python_ack, python_result, python_error,
    input  host_req_valid, host_req_kind, host_req_addr,
    input  bridge_busy, timeout_count, spurious_count
  );
endinterface

// File: rtl/engine_host_bridge.sv
// Shares one host mailbox between the Z3 and Python engine channels: round-robin on ties,
// per-transaction timeout with synthesized error responses, spurious response accounting.
//
//   state | meaning
//   IDLE  | sampling z3_req / python_req, no transaction open
//   ISSUE | host_req_valid held with latched kind/addr until host_req_ready
//   WAIT  | request accepted, counting cycles until host response or timeout
//   DONE  | response buffered; publish it with a one-cycle ack next edge
module engine_host_bridge #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                  clk,
  input logic                  rst_n,
  engine_host_bridge_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic        KIND_Z3 = 1'b0;
  localparam logic        KIND_PY = 1'b1;
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic        kind_q, kind_nxt;
  logic [31:0] addr_q;
  logic [15:0] wait_cnt;
  logic        last_grant;

  logic        grant_go, xfer, resp_take, timeout_hit, ack_go, spurious;

  logic [31:0] buf_data, buf_aux;
  logic        buf_flag;

  logic        z3_ack_q, z3_sat_q, py_ack_q, py_err_q;
  logic [31:0] z3_res_q, z3_cert_q, py_res_q;
  logic [15:0] to_cnt, sp_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    kind_nxt    = kind_q;
    grant_go    = 1'b0;
    xfer        = 1'b0;
    resp_take   = 1'b0;
    timeout_hit = 1'b0;
    ack_go      = 1'b0;
    spurious    = 1'b0;
    unique case (state)
      IDLE: begin
        spurious = bus.host_resp_valid;
        if (bus.z3_req && bus.python_req) begin
          grant_go = 1'b1;
          kind_nxt = ~last_grant;
        end else if (bus.z3_req) begin
          grant_go = 1'b1;
          kind_nxt = KIND_Z3;
        end else if (bus.python_req) begin
          grant_go = 1'b1;
          kind_nxt = KIND_PY;
        end
        if (grant_go) state_nxt = ISSUE;
      end
      ISSUE: begin
        spurious = bus.host_resp_valid;
        if (bus.host_req_ready) begin
          xfer      = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // A response landing on the last allowed cycle still counts as a real completion.
        if (bus.host_resp_valid) begin
          resp_take = 1'b1;
          state_nxt = DONE;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout_hit = 1'b1;
          state_nxt   = DONE;
        end
      end
      DONE: begin
        spurious  = bus.host_resp_valid;
        ack_go    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kind_q     <= KIND_Z3;
      addr_q     <= '0;
      wait_cnt   <= '0;
      last_grant <= KIND_PY;
      buf_data   <= '0;
      buf_aux    <= '0;
      buf_flag   <= 1'b0;
      z3_ack_q   <= 1'b0;
      z3_res_q   <= '0;
      z3_sat_q   <= 1'b0;
      z3_cert_q  <= '0;
      py_ack_q   <= 1'b0;
      py_res_q   <= '0;
      py_err_q   <= 1'b0;
      to_cnt     <= '0;
      sp_cnt     <= '0;
    end else begin
      z3_ack_q <= 1'b0;
      py_ack_q <= 1'b0;

      if (grant_go) begin
        kind_q <= kind_nxt;
        addr_q <= (kind_nxt == KIND_PY) ? bus.python_code_addr : bus.z3_formula_addr;
      end

      if (xfer)               wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 16'd1;

      if (resp_take) begin
        buf_data <= bus.host_resp_data;
        buf_aux  <= bus.host_resp_aux;
        buf_flag <= bus.host_resp_flag;
      end else if (timeout_hit) begin
        buf_data <= (kind_q == KIND_PY) ? 32'h0 : 32'hFFFF_FFFF;
        buf_aux  <= 32'h0;
        buf_flag <= (kind_q == KIND_PY);
        if (to_cnt != 16'hFFFF) to_cnt <= to_cnt + 16'd1;
      end

      if (spurious && sp_cnt != 16'hFFFF) sp_cnt <= sp_cnt + 16'd1;

      // Results are published together with the ack so the other channel never moves.
      if (ack_go) begin
        last_grant <= kind_q;
        if (kind_q == KIND_Z3) begin
          z3_ack_q  <= 1'b1;
          z3_res_q  <= buf_data;
          z3_cert_q <= buf_aux;
          z3_sat_q  <= buf_flag;
        end else begin
          py_ack_q <= 1'b1;
          py_res_q <= buf_data;
          py_err_q <= buf_flag;
        end
      end
    end
  end

  assign bus.host_req_valid = (state == ISSUE);
  assign bus.host_req_kind  = kind_q;
  assign bus.host_req_addr  = addr_q;
  assign bus.bridge_busy    = (state != IDLE);
  assign bus.z3_ack         = z3_ack_q;
  assign bus.z3_result      = z3_res_q;
  assign bus.z3_sat         = z3_sat_q;
  assign bus.z3_cert_hash   = z3_cert_q;
  assign bus.python_ack     = py_ack_q;
  assign bus.python_result  = py_res_q;
  assign bus.python_error   = py_err_q;
  assign bus.timeout_count  = to_cnt;
  assign bus.spurious_count = sp_cnt;

endmodule

// File: tb/tb_engine_host_bridge.sv
// Directed bench for engine_host_bridge: vector table of single transactions plus
// hand-written tie-break, spurious-response and mid-transaction reset sequences.
module tb_engine_host_bridge;

  localparam int TO = 8;
  localparam int NO_RESP = -1;

  logic clk;
  logic rst_n;
  engine_host_bridge_if bus();

  engine_host_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_py;
    logic [31:0] addr;
    int          rdy_dly;
    int          rsp_dly;
    logic [31:0] data;
    logic [31:0] aux;
    logic        flag;
    logic [31:0] exp_res;
    logic [31:0] exp_aux;
    logic        exp_flag;
    logic [15:0] exp_to;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];
  vec_t post_rst;

  int checks = 0;
  int errors = 0;
  int n_z3_ack = 0;
  int n_py_ack = 0;

  logic [31:0] sh_z3_res, sh_z3_cert, sh_py_res;
  logic        sh_z3_sat, sh_py_err;

  always @(posedge clk) begin
    if (bus.z3_ack)     n_z3_ack++;
    if (bus.python_ack) n_py_ack++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_z3_result"}, bus.z3_result, sh_z3_res);
    chk({tag, "_z3_cert"}, bus.z3_cert_hash, sh_z3_cert);
    chk({tag, "_z3_sat"}, 32'(bus.z3_sat), 32'(sh_z3_sat));
    chk({tag, "_py_result"}, bus.python_result, sh_py_res);
    chk({tag, "_py_error"}, 32'(bus.python_error), 32'(sh_py_err));
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int n;
    int lat;
    if (v.is_py) begin
      bus.python_req = 1'b1;
      bus.python_code_addr = v.addr;
    end else begin
      bus.z3_req = 1'b1;
      bus.z3_formula_addr = v.addr;
    end
    tick();
    n = 0;
    while (!bus.host_req_valid && n < 10) begin
      tick();
      n++;
    end
    chk({tag, "_grant_latency"}, n, 0);
    chk({tag, "_busy"}, 32'(bus.bridge_busy), 1);
    chk({tag, "_kind"}, 32'(bus.host_req_kind), 32'(v.is_py));
    chk({tag, "_addr"}, bus.host_req_addr, v.addr);
    for (int i = 0; i < v.rdy_dly; i++) begin
      tick();
      chk({tag, "_hold_valid"}, 32'(bus.host_req_valid), 1);
      chk({tag, "_hold_addr"}, bus.host_req_addr, v.addr);
    end
    bus.host_req_ready = 1'b1;
    tick();
    bus.host_req_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(bus.host_req_valid), 0);
    lat = 0;
    if (v.rsp_dly != NO_RESP) begin
      for (int i = 0; i < v.rsp_dly; i++) begin
        tick();
        lat++;
      end
      bus.host_resp_valid = 1'b1;
      bus.host_resp_data  = v.data;
      bus.host_resp_aux   = v.aux;
      bus.host_resp_flag  = v.flag;
      tick();
      lat++;
      bus.host_resp_valid = 1'b0;
    end
    n = 0;
    while (!bus.z3_ack && !bus.python_ack && n < 40) begin
      tick();
      lat++;
      n++;
    end
    chk({tag, "_ack_latency"}, lat, v.exp_lat);
    chk({tag, "_z3_ack"}, 32'(bus.z3_ack), 32'(!v.is_py));
    chk({tag, "_py_ack"}, 32'(bus.python_ack), 32'(v.is_py));
    if (v.is_py) begin
      sh_py_res = v.exp_res;
      sh_py_err = v.exp_flag;
    end else begin
      sh_z3_res  = v.exp_res;
      sh_z3_cert = v.exp_aux;
      sh_z3_sat  = v.exp_flag;
    end
    chk_outputs(tag);
    chk({tag, "_timeouts"}, 32'(bus.timeout_count), 32'(v.exp_to));
    bus.z3_req = 1'b0;
    bus.python_req = 1'b0;
    tick();
    chk({tag, "_ack_pulse"}, 32'(bus.z3_ack | bus.python_ack), 0);
    chk({tag, "_idle"}, 32'(bus.bridge_busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int z3_before, py_before;

    //        py   addr          rdy rsp      data          aux           f  exp_res       exp_aux       ef to lat
    vecs[0] = '{1'b0, 32'h0000_1234, 0, 0,       32'hDEAD_ACDB, 32'hC0FF_D234, 1'b1, 32'hDEAD_ACDB, 32'hC0FF_D234, 1'b1, 16'd0, 2};
    vecs[1] = '{1'b1, 32'h0000_ABCD, 0, 0,       32'h1234_FDB5, 32'h0000_0055, 1'b0, 32'h1234_FDB5, 32'h0,         1'b0, 16'd0, 2};
    vecs[2] = '{1'b0, 32'h0000_0040, 0, NO_RESP, 32'h0,         32'h0,         1'b0, 32'hFFFF_FFFF, 32'h0,         1'b0, 16'd1, TO + 1};
    vecs[3] = '{1'b1, 32'h0000_0080, 0, NO_RESP, 32'h0,         32'h0,         1'b0, 32'h0,         32'h0,         1'b1, 16'd2, TO + 1};
    vecs[4] = '{1'b0, 32'h0000_0100, 0, TO - 1,  32'hA5A5_0001, 32'h0000_0077, 1'b1, 32'hA5A5_0001, 32'h0000_0077, 1'b1, 16'd2, TO + 1};
    vecs[5] = '{1'b1, 32'h0000_0200, 3, 2,       32'h0BAD_F00D, 32'h0,         1'b1, 32'h0BAD_F00D, 32'h0,         1'b1, 16'd2, 4};
    vecs[6] = '{1'b0, 32'h0000_0300, 1, TO - 2,  32'h1357_9BDF, 32'h2468_ACE0, 1'b0, 32'h1357_9BDF, 32'h2468_ACE0, 1'b0, 16'd2, TO};
    post_rst = '{1'b1, 32'h0000_0777, 0, 1,     32'hCAFE_0001, 32'h0,         1'b1, 32'hCAFE_0001, 32'h0,         1'b1, 16'd0, 3};

    sh_z3_res = '0; sh_z3_cert = '0; sh_z3_sat = 1'b0; sh_py_res = '0; sh_py_err = 1'b0;
    bus.z3_req = 1'b0; bus.z3_formula_addr = '0;
    bus.python_req = 1'b0; bus.python_code_addr = '0;
    bus.host_req_ready = 1'b0; bus.host_resp_valid = 1'b0;
    bus.host_resp_data = '0; bus.host_resp_aux = '0; bus.host_resp_flag = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    chk("rst_valid", 32'(bus.host_req_valid), 0);
    chk("rst_kind", 32'(bus.host_req_kind), 0);
    chk("rst_addr", bus.host_req_addr, 0);
    chk("rst_busy", 32'(bus.bridge_busy), 0);
    chk("rst_acks", 32'(bus.z3_ack | bus.python_ack), 0);
    chk("rst_timeouts", 32'(bus.timeout_count), 0);
    chk("rst_spurious", 32'(bus.spurious_count), 0);
    chk_outputs("rst");

    // Tie right after reset: Z3 first, then Python; ready held low 5 cycles on the first.
    bus.z3_req = 1'b1; bus.z3_formula_addr = 32'h0000_0111;
    bus.python_req = 1'b1; bus.python_code_addr = 32'h0000_0222;
    tick();
    chk("tie1_valid", 32'(bus.host_req_valid), 1);
    chk("tie1_kind", 32'(bus.host_req_kind), 0);
    chk("tie1_addr", bus.host_req_addr, 32'h0000_0111);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("tie1_hold_valid", 32'(bus.host_req_valid), 1);
      chk("tie1_hold_addr", bus.host_req_addr, 32'h0000_0111);
    end
    bus.host_req_ready = 1'b1; tick(); bus.host_req_ready = 1'b0;
    bus.host_resp_valid = 1'b1; bus.host_resp_data = 32'hAAAA_0001;
    bus.host_resp_aux = 32'h0000_0002; bus.host_resp_flag = 1'b1;
    tick();
    bus.host_resp_valid = 1'b0;
    n = 0;
    while (!bus.z3_ack && !bus.python_ack && n < 20) begin tick(); n++; end
    chk("tie1_z3_ack", 32'(bus.z3_ack), 1);
    chk("tie1_py_ack", 32'(bus.python_ack), 0);
    sh_z3_res = 32'hAAAA_0001; sh_z3_cert = 32'h0000_0002; sh_z3_sat = 1'b1;
    chk_outputs("tie1");
    bus.z3_req = 1'b0;
    tick();
    chk("tie2_valid", 32'(bus.host_req_valid), 1);
    chk("tie2_kind", 32'(bus.host_req_kind), 1);
    chk("tie2_addr", bus.host_req_addr, 32'h0000_0222);
    bus.host_req_ready = 1'b1; tick(); bus.host_req_ready = 1'b0;
    bus.host_resp_valid = 1'b1; bus.host_resp_data = 32'hBBBB_0002;
    bus.host_resp_aux = 32'h0000_0009; bus.host_resp_flag = 1'b0;
    tick();
    bus.host_resp_valid = 1'b0;
    n = 0;
    while (!bus.z3_ack && !bus.python_ack && n < 20) begin tick(); n++; end
    chk("tie2_py_ack", 32'(bus.python_ack), 1);
    chk("tie2_z3_ack", 32'(bus.z3_ack), 0);
    sh_py_res = 32'hBBBB_0002; sh_py_err = 1'b0;
    chk_outputs("tie2");
    bus.python_req = 1'b0;
    tick();
    chk("tie_z3_ack_count", n_z3_ack, 1);
    chk("tie_py_ack_count", n_py_ack, 1);

    for (int i = 0; i < 7; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Two response strobes with nothing outstanding.
    z3_before = n_z3_ack;
    py_before = n_py_ack;
    for (int i = 0; i < 2; i++) begin
      bus.host_resp_valid = 1'b1; tick();
      bus.host_resp_valid = 1'b0; tick();
    end
    tick();
    chk("spur_count", 32'(bus.spurious_count), 2);
    chk("spur_busy", 32'(bus.bridge_busy), 0);
    chk("spur_z3_acks", n_z3_ack, z3_before);
    chk("spur_py_acks", n_py_ack, py_before);
    chk_outputs("spur");

    // Reset while a Z3 transaction is waiting on the host.
    bus.z3_req = 1'b1; bus.z3_formula_addr = 32'h0000_3000;
    tick();
    chk("mid_valid", 32'(bus.host_req_valid), 1);
    bus.host_req_ready = 1'b1; tick(); bus.host_req_ready = 1'b0;
    tick(); tick();
    chk("mid_busy", 32'(bus.bridge_busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.bridge_busy), 0);
    chk("arst_addr", bus.host_req_addr, 0);
    chk("arst_valid", 32'(bus.host_req_valid), 0);
    chk("arst_timeouts", 32'(bus.timeout_count), 0);
    chk("arst_spurious", 32'(bus.spurious_count), 0);
    sh_z3_res = '0; sh_z3_cert = '0; sh_z3_sat = 1'b0; sh_py_res = '0; sh_py_err = 1'b0;
    chk_outputs("arst");
    bus.z3_req = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    z3_before = n_z3_ack;
    bus.host_resp_valid = 1'b1; bus.host_resp_data = 32'h5A5A_5A5A; tick();
    bus.host_resp_valid = 1'b0; tick();
    chk("stale_spurious", 32'(bus.spurious_count), 1);
    chk("stale_busy", 32'(bus.bridge_busy), 0);
    chk("stale_no_ack", n_z3_ack, z3_before);
    run_txn(post_rst, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
